// File: rtl/load_store_unit.sv
// Data-side master for a single-port synchronous word RAM: byte/half/word loads and stores,
// sub-word stores done as read-modify-write. Latency from accept: error 0, word store 1, load 2,
// sub-word store 3 cycles to resp_valid. Backpressure: req_ready high only in IDLE, one request in flight.
//
// Ports:
//   clk, resetn                      clock (shared with RAM), async active-low reset
//   req_valid/req_ready              request handshake, fields latched on the accept edge
//   req_we, req_funct3               1 = store; RISC-V funct3 size/sign encoding
//   req_addr, req_wdata              byte address; right-aligned store data
//   resp_valid, resp_rdata, resp_err one-cycle completion pulse with formatted load data / error flag
//   mem_addr, mem_wdata, mem_rw      RAM word address (byte form), write word, 1 = read / 0 = write
//   mem_rdata                        RAM registered read data, valid the cycle after a read
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Request legality, evaluated on the live request fields at the accept edge.
  logic req_err;
  always_comb begin
    req_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) req_err = 1'b1;
    if (req_we && req_funct3[2])                                      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])                      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)           req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_W)                       req_err = 1'b1;
  end

  // Load formatting of the RAM word according to the latched size/sign and lane offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  always_comb begin
    ld_byte = 8'h00;
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    case (funct3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7]  & ~funct3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Sub-word store merge: only the addressed lane takes new data, the rest comes from the RAM word.
  logic [31:0] st_merge;
  always_comb begin
    st_merge = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (off_q)
        2'd0:    st_merge[7:0]   = wdata_q[7:0];
        2'd1:    st_merge[15:8]  = wdata_q[7:0];
        2'd2:    st_merge[23:16] = wdata_q[7:0];
        default: st_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      st_merge[31:16] = wdata_q[15:0];
    end else begin
      st_merge[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          funct3_d = req_funct3;
          we_d     = req_we;
          wdata_d  = req_wdata;
          if (req_err) begin
            // No RAM access at all: mem_addr keeps its previous value.
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = S_DONE;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_we && req_funct3[1:0] == 2'b10) begin
              mem_wdata_d = req_wdata;
              state_d     = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        if (we_q) begin
          mem_wdata_d = st_merge;
          state_d     = S_WR;
        end else begin
          resp_rdata_d = ld_data;
          state_d      = S_DONE;
        end
      end
      S_WR:  state_d = S_DONE;
      S_DONE: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'h0;
      off_q        <= 2'b00;
      funct3_q     <= 3'b000;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // mem_rw is decoded from the state register so an async reset forces it high immediately.
  assign mem_rw     = (state_q != S_WR);
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
